// File: rtl/uart_tx_fifo_rd.sv
// Pulls one byte at a time from the async TX FIFO and shifts it out as an 8N1 frame; request to start bit is 3 rclk.
// No backpressure beyond tx_en_i/empty_i gating one outstanding request; UART_TX_PARITY_EN adds an even parity bit.
module uart_tx_fifo_rd #(
   parameter int DATA_W = 8,
   parameter int DIV_W  = 16
) (
   input  logic              rclk,
   input  logic              rst_n,
   input  logic              tx_en_i,
   input  logic [DIV_W-1:0]  baud_div_i,
   input  logic              empty_i,
   input  logic              valid_i,
   input  logic [DATA_W-1:0] rdata_i,
   output logic              renc_o,
   output logic              tx_o,
   output logic              busy_o
);

   localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_WAIT   = 3'd1;
   localparam logic [2:0] S_START  = 3'd2;
   localparam logic [2:0] S_DATA   = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd5;
`ifdef UART_TX_PARITY_EN
   localparam logic [2:0] S_PARITY = 3'd4;
`endif

   logic [2:0]        state_q, state_d;
   logic [DIV_W-1:0]  cnt_q, cnt_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [BIT_W-1:0]  bit_q, bit_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic              tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
   logic              par_q, par_d;
`endif

   logic bit_end;
   logic req_ok;

   assign bit_end = (cnt_q == div_q);
   assign req_ok  = tx_en_i && !empty_i;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      div_d   = div_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      renc_o  = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d   = par_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (req_ok) begin
               renc_o  = 1'b1;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            // Baud divisor is frozen here so mid-frame changes wait for the next byte.
            if (valid_i) begin
               shift_d = rdata_i;
               div_d   = baud_div_i;
               cnt_d   = '0;
               state_d = S_START;
`ifdef UART_TX_PARITY_EN
               par_d   = ^rdata_i;
`endif
            end
         end
         S_START: begin
            if (bit_end) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = S_DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               cnt_d = '0;
               if (bit_q == BIT_W'(DATA_W - 1)) begin
`ifdef UART_TX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end else begin
                  bit_d   = bit_q + 1'b1;
                  shift_d = shift_q >> 1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (bit_end) begin
               cnt_d   = '0;
               state_d = S_STOP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
`endif
         S_STOP: begin
            // Requesting in the last stop cycle keeps the inter-frame gap at the FIFO latency.
            if (bit_end) begin
               cnt_d = '0;
               if (req_ok) begin
                  renc_o  = 1'b1;
                  state_d = S_WAIT;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      case (state_d)
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
         S_PARITY: tx_d = par_d;
`endif
         default:  tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge rclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         div_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   assign tx_o   = tx_q;
   assign busy_o = (state_q != S_IDLE);

endmodule
